// File: rtl/sma_pkg.sv
// Shared types and constants for the SMA output reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sma_pkg;

    localparam int DATA_W  = 32;
    localparam int SEL_MAX = 15;
    localparam int CNT_W   = 17;
    localparam int DEC_W   = 16;
    localparam int SEL_W   = 4;
    localparam int TAG_W   = 4;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Strobes needed to fill a window of 2^sel samples, plus the averager's
    // two-stage window register delay before its output reflects the new window.
    function automatic logic [CNT_W-1:0] prime_target(input logic [SEL_W-1:0] sel);
        return (CNT_W'(1) << sel) + CNT_W'(2);
    endfunction

endpackage

// File: rtl/sma_rd_fifo2.sv
// Two-entry registered FIFO; head is always a register output.
// Latency: push visible at head one cycle later when empty.
// Backpressure: push while full without pop is ignored (caller flags the drop).
module sma_rd_fifo2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] ent0;
    logic [WIDTH-1:0] ent1;
    logic [1:0]       count;
    logic             do_pop;

    assign do_pop = pop & (count != 2'd0);
    assign empty  = (count == 2'd0);
    assign full   = (count == 2'd2);
    assign head   = ent0;

    // Storage update; ent0 is never cleared on pop so the last value stays visible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent0  <= '0;
            ent1  <= '0;
            count <= 2'd0;
        end else begin
            case (count)
                2'd0: begin
                    if (push) begin
                        ent0  <= push_data;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && do_pop) begin
                        ent0 <= push_data;
                    end else if (push) begin
                        ent1  <= push_data;
                        count <= 2'd2;
                    end else if (do_pop) begin
                        count <= 2'd0;
                    end
                end
                default: begin
                    // Full: a simultaneous pop frees the slot the push needs.
                    if (do_pop) begin
                        ent0 <= ent1;
                        if (push) begin
                            ent1 <= push_data;
                        end else begin
                            count <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/sma_out_reader.sv
// SMA output reader: gates output until the window is primed, decimates, buffers 2 deep.
// Latency: pushing strobe at cycle t gives o_valid at t+1 when the buffer was empty.
// Backpressure: i_ready stalls the 2-entry buffer; pushes into a full, non-popping buffer drop and set o_overflow.
// Optional: define SMA_RD_TAG_EN to add o_tag (window select captured per sample).
module sma_out_reader
    import sma_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_update_strobe,
    input  logic [DATA_W-1:0] i_data,
    input  logic [31:0]       i_window_sel,
    input  logic [DEC_W-1:0]  i_decim,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_primed,
    output logic              o_overflow,
`ifdef SMA_RD_TAG_EN
    output logic [TAG_W-1:0]  o_tag,
`endif
    input  logic              i_clr_ovf
);

`ifdef SMA_RD_TAG_EN
    localparam int FW = DATA_W + TAG_W;
`else
    localparam int FW = DATA_W;
`endif

    logic [SEL_W-1:0] sel_eff;
    logic [SEL_W-1:0] sel_q;
    logic             win_chg;
    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] pcnt;
    logic [CNT_W-1:0] pcnt_nx;
    logic [DEC_W-1:0] dcnt;
    logic [DEC_W-1:0] dcnt_nx;
    logic [DEC_W-1:0] dec_q;
    logic [DEC_W-1:0] dec_nx;
    logic             ovf;
    logic             ovf_nx;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [FW-1:0]    push_data;
    logic [FW-1:0]    head;

    // Clamp the requested window to the largest supported one.
    always_comb begin
        sel_eff = SEL_W'(SEL_MAX);
        if (i_window_sel <= 32'(SEL_MAX)) begin
            sel_eff = i_window_sel[SEL_W-1:0];
        end
    end

    // Track the window select even during reset so the first post-reset cycle
    // does not look like a window change and swallow a strobe.
    always_ff @(posedge i_clk) begin
        sel_q <= sel_eff;
    end

    assign win_chg = (sel_eff != sel_q);

    // FSM next state, priming/decimation counters, buffer push and overflow.
    always_comb begin
        state_nx = state;
        pcnt_nx  = pcnt;
        dcnt_nx  = dcnt;
        dec_nx   = dec_q;
        push     = 1'b0;
        if (win_chg) begin
            state_nx = PRIME;
            pcnt_nx  = '0;
        end else if (i_update_strobe) begin
            case (state)
                PRIME: begin
                    if (pcnt == prime_target(sel_q) - CNT_W'(1)) begin
                        state_nx = RUN;
                        pcnt_nx  = '0;
                        dcnt_nx  = '0;
                        dec_nx   = i_decim;
                    end else begin
                        pcnt_nx = pcnt + CNT_W'(1);
                    end
                end
                default: begin
                    if (dcnt == dec_q) begin
                        push    = 1'b1;
                        dcnt_nx = '0;
                        dec_nx  = i_decim;
                    end else begin
                        dcnt_nx = dcnt + DEC_W'(1);
                    end
                end
            endcase
        end
        ovf_nx = ovf;
        if (push && full && !pop) begin
            ovf_nx = 1'b1;
        end else if (i_clr_ovf) begin
            ovf_nx = 1'b0;
        end
    end

    // State and counter registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= PRIME;
            pcnt  <= '0;
            dcnt  <= '0;
            dec_q <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            pcnt  <= pcnt_nx;
            dcnt  <= dcnt_nx;
            dec_q <= dec_nx;
            ovf   <= ovf_nx;
        end
    end

`ifdef SMA_RD_TAG_EN
    assign push_data = {sel_q, i_data};
    assign o_tag     = head[FW-1:DATA_W];
`else
    assign push_data = i_data;
`endif

    assign pop        = o_valid & i_ready;
    assign o_valid    = ~empty;
    assign o_data     = head[DATA_W-1:0];
    assign o_primed   = (state == RUN);
    assign o_overflow = ovf;

    sma_rd_fifo2 #(
        .WIDTH (FW)
    ) u_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

endmodule

// File: tb/tb_sma_out_reader.sv
// Bench for sma_out_reader: directed strobes feed an expected-data queue,
// a negedge monitor pops and compares on every accepted output,
// and direct checks cover reset, priming, window change and overflow.
module tb_sma_out_reader;
    import sma_pkg::*;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_update_strobe;
    logic [DATA_W-1:0] i_data;
    logic [31:0]       i_window_sel;
    logic [DEC_W-1:0]  i_decim;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              i_ready;
    logic              o_primed;
    logic              o_overflow;
    logic              i_clr_ovf;
`ifdef SMA_RD_TAG_EN
    logic [TAG_W-1:0]  o_tag;
`endif

    int errors = 0;
    int checks = 0;
    logic [DATA_W-1:0] exp_q[$];

    always #5 i_clk = ~i_clk;

    sma_out_reader dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_update_strobe (i_update_strobe),
        .i_data          (i_data),
        .i_window_sel    (i_window_sel),
        .i_decim         (i_decim),
        .o_data          (o_data),
        .o_valid         (o_valid),
        .i_ready         (i_ready),
        .o_primed        (o_primed),
        .o_overflow      (o_overflow),
`ifdef SMA_RD_TAG_EN
        .o_tag           (o_tag),
`endif
        .i_clr_ovf       (i_clr_ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic strobe(input int d, input bit emit);
        i_update_strobe = 1'b1;
        i_data          = DATA_W'(d);
        if (emit) exp_q.push_back(DATA_W'(d));
        tick();
    endtask

    task automatic idle(input int n);
        i_update_strobe = 1'b0;
        repeat (n) tick();
    endtask

    // Monitor: every accepted output must match the oldest expected sample.
    always @(negedge i_clk) begin
        if (i_rst_n && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0d expected none", o_data);
            end else begin
                check("pop_data", o_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        i_rst_n         = 1'b0;
        i_update_strobe = 1'b0;
        i_data          = '0;
        i_window_sel    = 32'd2;
        i_decim         = '0;
        i_ready         = 1'b1;
        i_clr_ovf       = 1'b0;
        repeat (3) tick();
        check("rst_valid", o_valid, 0);
        check("rst_data", o_data, 0);
        check("rst_primed", o_primed, 0);
        check("rst_ovf", o_overflow, 0);

        // Prime with sel=2 (6 strobes), then every strobe is emitted.
        i_rst_n = 1'b1;
        for (int d = 1; d <= 5; d++) strobe(d, 1'b0);
        check("prime5_primed", o_primed, 0);
        strobe(6, 1'b0);
        check("prime6_primed", o_primed, 1);
        check("prime6_valid", o_valid, 0);
        strobe(7, 1'b1);
        check("first_valid", o_valid, 1);
        check("first_data", o_data, 7);
        for (int d = 8; d <= 10; d++) strobe(d, 1'b1);
        idle(2);

        // Decimate by 4: old factor 0 emits 11, then every 4th strobe.
        i_decim = 16'd3;
        for (int d = 11; d <= 19; d++) begin
            strobe(d, (d == 11) || (d == 15) || (d == 19));
            check("decim_primed", o_primed, 1);
            check("decim_valid", o_valid, ((d == 11) || (d == 15) || (d == 19)) ? 1 : 0);
        end
        idle(2);

        // Window change 2->4 with one sample buffered; the coincident strobe is ignored.
        i_ready = 1'b0;
        for (int d = 20; d <= 23; d++) strobe(d, d == 23);
        i_window_sel = 32'd4;
        strobe(24, 1'b0);
        check("win_primed", o_primed, 0);
        check("win_keep_valid", o_valid, 1);
        check("win_keep_data", o_data, 23);
        i_ready = 1'b1;
        i_decim = 16'd0;
        for (int d = 25; d <= 41; d++) strobe(d, 1'b0);
        check("win_prime17_primed", o_primed, 0);
        check("win_prime17_valid", o_valid, 0);
        strobe(42, 1'b0);
        check("win_prime18_primed", o_primed, 1);
        check("win_prime18_valid", o_valid, 0);
        strobe(43, 1'b1);
        check("win_first_valid", o_valid, 1);
        check("win_first_data", o_data, 43);
        idle(2);

        // Overflow: two samples fill the buffer, the rest drop.
        i_ready = 1'b0;
        strobe(50, 1'b1);
        strobe(51, 1'b1);
        check("full_no_drop_ovf", o_overflow, 0);
        strobe(52, 1'b0);
        check("drop_ovf", o_overflow, 1);
        i_clr_ovf = 1'b1;
        strobe(53, 1'b0);
        i_clr_ovf = 1'b0;
        check("ovf_set_beats_clr", o_overflow, 1);
        check("ovf_head_data", o_data, 50);
        i_update_strobe = 1'b0;
        i_clr_ovf = 1'b1;
        tick();
        i_clr_ovf = 1'b0;
        check("clr_ovf", o_overflow, 0);
        check("clr_head_data", o_data, 50);

        // Full buffer with simultaneous push and pop: nothing dropped.
        i_ready = 1'b1;
        strobe(54, 1'b1);
        check("full_pushpop_ovf", o_overflow, 0);
        check("full_pushpop_head", o_data, 51);
        strobe(55, 1'b1);
        check("full_pushpop2_ovf", o_overflow, 0);
        check("full_pushpop2_head", o_data, 54);
        idle(3);
        check("drained_valid", o_valid, 0);
        check("drained_last_data", o_data, 55);

        // Reset mid-RUN with a full buffer; buffered samples are discarded.
        i_ready = 1'b0;
        strobe(60, 1'b0);
        strobe(61, 1'b0);
        check("pre_rst_valid", o_valid, 1);
        i_update_strobe = 1'b0;
        i_rst_n = 1'b0;
        i_window_sel = 32'd2;
        tick();
        check("rst2_valid", o_valid, 0);
        check("rst2_data", o_data, 0);
        check("rst2_primed", o_primed, 0);
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        for (int d = 70; d <= 74; d++) strobe(d, 1'b0);
        check("reprime5_primed", o_primed, 0);
        strobe(75, 1'b0);
        check("reprime6_primed", o_primed, 1);
        check("reprime6_valid", o_valid, 0);
        strobe(76, 1'b1);
        check("reprime_first_data", o_data, 76);
        idle(3);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
